// File: rtl/icache_loader.sv
// icache_loader: boot/refill controller for the instruction cache.
// Copies DEPTH words from backing memory into the icache after reset and on
// every flush, holding the fetch unit in reset until the image is complete.
// In RUN the fetch unit's next-PC index is passed straight to the cache, and
// single-cycle debug writes are granted.
module icache_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 64,
  parameter logic [MEM_AW-1:0] BASE_ADDR = {MEM_AW{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_flush,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              ic_wren,
  output logic [ADDR_W-1:0] ic_address,
  output logic [DATA_W-1:0] ic_data,
  output logic              fetch_reset,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    REQ   = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    DBG   = 3'd4
  } state_t;

  // Load counter saturates at the full image size.
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_IDX   = {ADDR_W{1'b1}};

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   idx_inc;
  logic [DATA_W-1:0]   wdata;
  logic                dbg_take;

  // Byte address of icache word i; the index is zero-extended to MEM_AW and
  // the sum wraps modulo 2^MEM_AW.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [ADDR_W-1:0] i);
    logic [MEM_AW-1:0] offset;
    offset = {MEM_AW{1'b0}};
    offset[ADDR_W+1:0] = {i, 2'b00};
    return BASE_ADDR + offset;
  endfunction

  assign idx_inc = idx + 1'b1;

  // A debug write is only granted in RUN, and a flush in the same cycle wins.
  assign dbg_ready = (state == RUN) && !start_flush;
  assign dbg_take  = dbg_ready && dbg_valid;

  // Load sequencer: owns the memory request, the word index and the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      idx        <= {ADDR_W{1'b0}};
      wdata      <= {DATA_W{1'b0}};
      load_count <= {(ADDR_W+1){1'b0}};
      mem_req    <= 1'b0;
      mem_addr   <= BASE_ADDR;
    end else begin
      case (state)
        INIT: begin
          // One idle cycle after reset, then ask for word 0.
          mem_req  <= 1'b1;
          mem_addr <= word_addr(idx);
          state    <= REQ;
        end
        REQ: begin
          // Request and address stay put until memory answers.
          if (mem_ack) begin
            wdata   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (load_count != FULL_COUNT) begin
            load_count <= load_count + 1'b1;
          end
          if (idx == LAST_IDX) begin
            state <= RUN;
          end else begin
            idx      <= idx_inc;
            mem_req  <= 1'b1;
            mem_addr <= word_addr(idx_inc);
            state    <= REQ;
          end
        end
        RUN: begin
          if (start_flush) begin
            idx        <= {ADDR_W{1'b0}};
            load_count <= {(ADDR_W+1){1'b0}};
            mem_req    <= 1'b1;
            mem_addr   <= word_addr({ADDR_W{1'b0}});
            state      <= REQ;
          end else if (dbg_valid) begin
            // dbg_ready is high here, so the write was taken this cycle.
            state <= DBG;
          end
        end
        DBG: begin
          // Fetch sat in reset for this cycle and restarts from pc 0.
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Cache port mux and fetch/busy flags; in RUN the fetch index and any
  // accepted debug write reach the cache with no added latency.
  always_comb begin
    ic_wren     = 1'b0;
    ic_address  = idx;
    ic_data     = wdata;
    fetch_reset = 1'b1;
    busy        = 1'b1;
    case (state)
      WRITE: begin
        ic_wren = 1'b1;
      end
      RUN: begin
        busy        = 1'b0;
        fetch_reset = dbg_take;
        if (dbg_take) begin
          ic_wren    = 1'b1;
          ic_address = dbg_addr;
          ic_data    = dbg_data;
        end else begin
          ic_address = fetch_addr;
        end
      end
      DBG: begin
        busy       = 1'b0;
        ic_address = fetch_addr;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_icache_loader.sv
// Bench for icache_loader: a memory responder with a write scoreboard, a
// table of RUN-mode vectors, and sequences for delayed acks, debug writes,
// flushes and a mid-load reset. A second 16-word instance covers BASE_ADDR.
module tb_icache_loader;

  logic        clock;
  logic        reset;
  logic        start_flush;
  logic [7:0]  fetch_addr;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        dbg_valid;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        ic_wren;
  logic [7:0]  ic_address;
  logic [31:0] ic_data;
  logic        fetch_reset;
  logic        busy;
  logic [8:0]  load_count;

  logic        s_start_flush;
  logic [3:0]  s_fetch_addr;
  logic        s_mem_req;
  logic [63:0] s_mem_addr;
  logic        s_mem_ack;
  logic [31:0] s_mem_rdata;
  logic        s_dbg_valid;
  logic [3:0]  s_dbg_addr;
  logic [31:0] s_dbg_data;
  logic        s_dbg_ready;
  logic        s_ic_wren;
  logic [3:0]  s_ic_address;
  logic [31:0] s_ic_data;
  logic        s_fetch_reset;
  logic        s_busy;
  logic [4:0]  s_load_count;

  icache_loader dut (
    .clock(clock), .reset(reset), .start_flush(start_flush), .fetch_addr(fetch_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .ic_wren(ic_wren), .ic_address(ic_address), .ic_data(ic_data),
    .fetch_reset(fetch_reset), .busy(busy), .load_count(load_count)
  );

  icache_loader #(.ADDR_W(4), .DATA_W(32), .MEM_AW(64), .BASE_ADDR(64'h1000_0000)) dut_s (
    .clock(clock), .reset(reset), .start_flush(s_start_flush), .fetch_addr(s_fetch_addr),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(s_mem_ack), .mem_rdata(s_mem_rdata),
    .dbg_valid(s_dbg_valid), .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data), .dbg_ready(s_dbg_ready),
    .ic_wren(s_ic_wren), .ic_address(s_ic_address), .ic_data(s_ic_data),
    .fetch_reset(s_fetch_reset), .busy(s_busy), .load_count(s_load_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control from the main sequence to the memory responder.
  logic [7:0] delay_word;
  int         delay_cyc;
  logic       inject_ack;

  // Counters, one set per process.
  int chk_m, err_m, chk_b, err_b, chk_s, err_s;

  // Scoreboard for load writes of the 256-word instance.
  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         exp_q[$];
  logic [7:0]  exp_word;
  int          wait_cnt;
  int          mem_writes;
  int          dbg_writes;
  logic [7:0]  last_dbg_addr;
  logic [31:0] last_dbg_data;

  // Memory responder + write monitor for the 256-word instance.
  initial begin
    wr_t         e;
    logic [63:0] ea;
    int          lat;
    exp_word = 8'd0; wait_cnt = 0; mem_writes = 0; dbg_writes = 0;
    chk_b = 0; err_b = 0; mem_ack = 1'b0; mem_rdata = 32'd0;
    last_dbg_addr = 8'd0; last_dbg_data = 32'd0;
    forever begin
      @(negedge clock);
      if (reset && ic_wren) begin
        if (busy) begin
          chk_b++;
          if (exp_q.size() == 0) begin
            err_b++;
            $display("FAIL load_write_unexpected: ic_address=%h ic_data=%h, required no write", ic_address, ic_data);
          end else begin
            e = exp_q.pop_front();
            if (ic_address !== e.a || ic_data !== e.d) begin
              err_b++;
              $display("FAIL load_write: got addr %h data %h, required addr %h data %h", ic_address, ic_data, e.a, e.d);
            end
            mem_writes++;
          end
        end else begin
          dbg_writes++;
          last_dbg_addr = ic_address;
          last_dbg_data = ic_data;
        end
      end
      @(posedge clock);
      #1;
      mem_ack   = inject_ack;
      mem_rdata = 32'd0;
      if (!reset) begin
        exp_word = 8'd0; wait_cnt = 0; exp_q.delete(); mem_ack = 1'b0;
      end else if (mem_req) begin
        ea = {54'd0, exp_word, 2'b00};
        chk_b++;
        if (mem_addr !== ea) begin
          err_b++;
          $display("FAIL mem_addr: got %h, required %h", mem_addr, ea);
        end
        lat = (exp_word == delay_word) ? delay_cyc : 0;
        if (wait_cnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = {24'd0, exp_word} ^ 32'hA5A5_A5A5;
          exp_q.push_back({exp_word, mem_rdata});
          exp_word  = exp_word + 8'd1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Responder + monitor for the 16-word instance at BASE_ADDR 0x1000_0000.
  int          s_cnt;
  int          s_rq;
  logic [63:0] s_last_addr;
  initial begin
    logic [63:0] ea;
    logic [31:0] ed;
    s_cnt = 0; s_rq = 0; s_last_addr = 64'd0; chk_s = 0; err_s = 0;
    s_mem_ack = 1'b0; s_mem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (reset && s_ic_wren) begin
        ed = 32'h1000_0000 + 32'(s_cnt) * 32'd4;
        chk_s++;
        if (s_ic_address !== 4'(s_cnt) || s_ic_data !== ed) begin
          err_s++;
          $display("FAIL small_write: got addr %h data %h, required addr %h data %h", s_ic_address, s_ic_data, 4'(s_cnt), ed);
        end
        s_cnt++;
      end
      @(posedge clock);
      #1;
      s_mem_ack = 1'b0;
      if (!reset) begin
        s_cnt = 0; s_rq = 0;
      end else if (s_mem_req) begin
        ea = 64'h1000_0000 + 64'(s_rq) * 64'd4;
        chk_s++;
        if (s_mem_addr !== ea) begin
          err_s++;
          $display("FAIL small_mem_addr: got %h, required %h", s_mem_addr, ea);
        end
        s_last_addr = s_mem_addr;
        s_mem_ack   = 1'b1;
        s_mem_rdata = s_mem_addr[31:0];
        s_rq++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_m++;
    if (got !== exp) begin
      err_m++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Counts clocks until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end while (busy && n < 3000);
  endtask

  // Waits until the scoreboard has seen a given number of load writes, bounded.
  task automatic wait_writes(input int target, input string name);
    int n;
    n = 0;
    while (mem_writes < target && n < 3000) begin
      @(posedge clock);
      n++;
    end
    check(name, 64'(mem_writes >= target), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  fa;
    logic        dv;
    logic [7:0]  da;
    logic [31:0] dd;
    logic        sf;
    logic        ewren;
    logic [7:0]  eaddr;
    logic [31:0] edata;
    logic        erdy;
    logic        efr;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n;
    int base;
    vecs[0] = '{8'h42, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 8'h42, 32'h0,         1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 8'hFF, 32'h0,         1'b1, 1'b0};
    vecs[3] = '{8'h42, 1'b1, 8'h10, 32'hDEADBEEF,  1'b0, 1'b1, 8'h10, 32'hDEADBEEF,  1'b1, 1'b1};
    vecs[4] = '{8'h33, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 8'h33, 32'h0,         1'b0, 1'b0};
    vecs[5] = '{8'h42, 1'b1, 8'h10, 32'hCAFEF00D,  1'b1, 1'b0, 8'h42, 32'h0,         1'b0, 1'b0};
    vecs[6] = '{8'h7E, 1'b1, 8'hFF, 32'h01234567,  1'b0, 1'b1, 8'hFF, 32'h01234567,  1'b1, 1'b1};

    chk_m = 0; err_m = 0;
    reset = 1'b1; start_flush = 1'b0; fetch_addr = 8'd0;
    dbg_valid = 1'b0; dbg_addr = 8'd0; dbg_data = 32'd0;
    inject_ack = 1'b0; delay_word = 8'd0; delay_cyc = 0;
    s_start_flush = 1'b0; s_fetch_addr = 4'd0; s_dbg_valid = 1'b0;
    s_dbg_addr = 4'd0; s_dbg_data = 32'd0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_mem_req",     64'(mem_req),     64'd0);
    check("rst_mem_addr",    mem_addr,         64'd0);
    check("rst_ic_wren",     64'(ic_wren),     64'd0);
    check("rst_ic_address",  64'(ic_address),  64'd0);
    check("rst_ic_data",     64'(ic_data),     64'd0);
    check("rst_fetch_reset", 64'(fetch_reset), 64'd1);
    check("rst_busy",        64'(busy),        64'd1);
    check("rst_dbg_ready",   64'(dbg_ready),   64'd0);
    check("rst_load_count",  64'(load_count),  64'd0);
    check("rst_small_addr",  s_mem_addr,       64'h1000_0000);

    // Boot load with single-cycle acks
    reset = 1'b1;
    wait_idle(n);
    check("load1_cycles",      64'(n),           64'd513);
    check("load1_writes",      64'(mem_writes),  64'd256);
    check("load1_count",       64'(load_count),  64'd256);
    check("load1_fetch_reset", 64'(fetch_reset), 64'd0);
    check("load1_busy",        64'(busy),        64'd0);
    check("load1_last_addr",   mem_addr,         64'h3FC);
    check("load1_queue_empty", 64'(exp_q.size()), 64'd0);

    // RUN-mode vectors, restored before the next edge
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #2;
      fetch_addr = vecs[i].fa; dbg_valid = vecs[i].dv; dbg_addr = vecs[i].da;
      dbg_data = vecs[i].dd; start_flush = vecs[i].sf;
      #1;
      check($sformatf("vec%0d_ic_wren", i),     64'(ic_wren),     64'(vecs[i].ewren));
      check($sformatf("vec%0d_ic_address", i),  64'(ic_address),  64'(vecs[i].eaddr));
      check($sformatf("vec%0d_dbg_ready", i),   64'(dbg_ready),   64'(vecs[i].erdy));
      check($sformatf("vec%0d_fetch_reset", i), 64'(fetch_reset), 64'(vecs[i].efr));
      if (vecs[i].ewren) check($sformatf("vec%0d_ic_data", i), 64'(ic_data), 64'(vecs[i].edata));
      #1;
      dbg_valid = 1'b0; start_flush = 1'b0;
    end

    // Stray ack while idle: no write, no state change
    @(posedge clock); #2 inject_ack = 1'b1;
    @(posedge clock); #2 inject_ack = 1'b0;
    @(negedge clock);
    check("idle_ack_busy",   64'(busy),       64'd0);
    check("idle_ack_wren",   64'(ic_wren),    64'd0);
    check("idle_ack_writes", 64'(mem_writes), 64'd256);

    // Debug write: one pulse, fetch_reset high two cycles
    @(posedge clock); #2;
    fetch_addr = 8'h42; dbg_valid = 1'b1; dbg_addr = 8'h10; dbg_data = 32'hDEADBEEF;
    #1;
    check("dbg_wren",        64'(ic_wren),     64'd1);
    check("dbg_address",     64'(ic_address),  64'h10);
    check("dbg_data",        64'(ic_data),     64'hDEADBEEF);
    check("dbg_fr_cycle1",   64'(fetch_reset), 64'd1);
    @(posedge clock); #2 dbg_valid = 1'b0;
    #1;
    check("dbg_fr_cycle2",   64'(fetch_reset), 64'd1);
    check("dbg_ready_in_dbg", 64'(dbg_ready),  64'd0);
    check("dbg_wren_in_dbg", 64'(ic_wren),     64'd0);
    check("dbg_addr_in_dbg", 64'(ic_address),  64'h42);
    @(posedge clock); #3;
    check("dbg_fr_after",    64'(fetch_reset), 64'd0);
    check("dbg_ready_after", 64'(dbg_ready),   64'd1);
    check("dbg_write_count", 64'(dbg_writes),  64'd1);
    check("dbg_write_addr",  64'(last_dbg_addr), 64'h10);
    check("dbg_write_data",  64'(last_dbg_data), 64'hDEADBEEF);

    // Flush and debug together: flush wins; reload with word 7 delayed
    delay_word = 8'd7; delay_cyc = 5;
    @(posedge clock); #2;
    start_flush = 1'b1; dbg_valid = 1'b1; dbg_addr = 8'h20; dbg_data = 32'h12345678;
    #1;
    check("flush_dbg_ready", 64'(dbg_ready), 64'd0);
    check("flush_dbg_wren",  64'(ic_wren),   64'd0);
    @(posedge clock); #2 start_flush = 1'b0; dbg_valid = 1'b0;
    #1;
    check("flush_busy",        64'(busy),        64'd1);
    check("flush_fetch_reset", 64'(fetch_reset), 64'd1);
    check("flush_load_count",  64'(load_count),  64'd0);
    check("flush_mem_req",     64'(mem_req),     64'd1);
    check("flush_mem_addr",    mem_addr,         64'd0);
    wait_writes(276, "load2_reach_word20");
    @(posedge clock); #2 start_flush = 1'b1;
    @(posedge clock); #2 start_flush = 1'b0;
    wait_idle(n);
    check("load2_busy",       64'(busy),       64'd0);
    check("load2_writes",     64'(mem_writes), 64'd512);
    check("load2_count",      64'(load_count), 64'd256);
    check("load2_dbg_writes", 64'(dbg_writes), 64'd1);
    check("load2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted mid-REQ on word 100
    delay_word = 8'd100; delay_cyc = 3;
    @(posedge clock); #2 start_flush = 1'b1;
    @(posedge clock); #2 start_flush = 1'b0;
    wait_writes(612, "load3_reach_word100");
    #2;
    check("mid_req_before",  64'(mem_req), 64'd1);
    check("mid_addr_before", mem_addr,     64'h190);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_mem_req", 64'(mem_req),     64'd0);
    check("mid_rst_busy",    64'(busy),        64'd1);
    check("mid_rst_fr",      64'(fetch_reset), 64'd1);
    check("mid_rst_count",   64'(load_count),  64'd0);
    delay_cyc = 0;
    @(negedge clock);
    @(negedge clock);
    base = mem_writes;
    reset = 1'b1;
    wait_idle(n);
    check("load4_cycles", 64'(n),                 64'd513);
    check("load4_writes", 64'(mem_writes - base), 64'd256);
    check("load4_count",  64'(load_count),        64'd256);
    check("load4_busy",   64'(busy),              64'd0);

    // 16-word instance at BASE_ADDR 0x1000_0000
    check("small_writes",      64'(s_cnt),         64'd16);
    check("small_load_count",  64'(s_load_count), 64'd16);
    check("small_busy",        64'(s_busy),        64'd0);
    check("small_fetch_reset", 64'(s_fetch_reset), 64'd0);
    check("small_last_addr",   s_last_addr,        64'h1000_003C);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", chk_m + chk_b + chk_s, err_m + err_b + err_s);
    $finish;
  end

endmodule
